// File: rtl/write_back_arbiter_if.sv
// Register-file write-back bundle: pipeline result, multi-cycle result
// handshake and the single register-file write port.
// The arbiter attaches through the slave modport; the producer/consumer side
// (pipeline, multi-cycle unit, register file) uses the master modport.
interface write_back_arbiter_if;
  logic        PipeEn;
  logic [4:0]  PipeAddr;
  logic [31:0] PipeData;
  logic        PipeStall;
  logic        MulValid;
  logic [4:0]  MulAddr;
  logic [31:0] MulData;
  logic        MulReady;
  logic        EnW;
  logic [4:0]  AddrW;
  logic [31:0] DataW;
  logic        MulPending;

  modport master (
    output PipeEn, PipeAddr, PipeData, MulValid, MulAddr, MulData,
    input  PipeStall, MulReady, EnW, AddrW, DataW, MulPending
  );

  modport slave (
    input  PipeEn, PipeAddr, PipeData, MulValid, MulAddr, MulData,
    output PipeStall, MulReady, EnW, AddrW, DataW, MulPending
  );
endinterface

// File: rtl/write_back_arbiter.sv
// write_back_arbiter: sole driver of the register-file write port. Merges the
// in-order pipeline writeback (no backpressure) with results from the
// multi-cycle unit, which are buffered in a small FIFO. The pipeline has
// priority; the FIFO drains in the gaps.
// Optional feature macro: WB_STARVE_GUARD_EN adds a starvation counter that
// forces the FIFO head through (stalling the pipeline for one cycle) after
// STARVE_LIMIT consecutive blocked cycles. Without it PipeStall is tied low.
`ifndef IDX_ZR
`define IDX_ZR 5'd31
`endif

module write_back_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  write_back_arbiter_if.slave  wb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrZero   = AW'(1'b0);
  localparam logic [AW-1:0] PtrOne    = AW'(1'b1);
  localparam logic [AW:0]   CountZero = (AW+1)'(1'b0);
  localparam logic [AW:0]   CountOne  = (AW+1)'(1'b1);
  localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);

  logic [4:0]    addrMemR [DEPTH];
  logic [31:0]   dataMemR [DEPTH];
  logic [AW-1:0] wrPtrR;
  logic [AW-1:0] rdPtrR;
  logic [AW:0]   countR;

  logic          fifoNonEmptyS;
  logic          pushS;
  logic          storeS;
  logic          pipeEffS;
  logic          forcedS;
  logic          popS;
  logic          selValidS;
  logic [4:0]    selAddrS;
  logic [31:0]   selDataS;

  assign fifoNonEmptyS = (countR != CountZero);
  // Ready looks only at the registered count: no credit for a same-cycle pop.
  assign wb.MulReady   = !Reset && (countR < FullCount);
  assign wb.MulPending = fifoNonEmptyS;
  assign pushS         = wb.MulValid && wb.MulReady;
  // Results for the zero register complete the handshake but are dropped.
  assign storeS        = pushS && (wb.MulAddr != `IDX_ZR);
  assign pipeEffS      = wb.PipeEn && (wb.PipeAddr != `IDX_ZR);

`ifdef WB_STARVE_GUARD_EN
  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);
  logic [7:0] starveR;

  assign forcedS = fifoNonEmptyS && (starveR == StarveMax);

  // Count consecutive cycles the FIFO head loses to the pipeline
  always_ff @(posedge Clock) begin
    if (Reset) begin
      starveR <= 8'd0;
    end else if (popS || !fifoNonEmptyS) begin
      starveR <= 8'd0;
    end else if (pipeEffS) begin
      starveR <= starveR + 8'd1;
    end else begin
      starveR <= starveR;
    end
  end
`else
  logic [7:0] unusedStarveLimitS;
  assign unusedStarveLimitS = 8'(STARVE_LIMIT);
  assign forcedS            = 1'b0;
`endif

  assign wb.PipeStall = forcedS && !Reset;

  // Pick this cycle's writer: forced head, then pipeline, then FIFO head
  always_comb begin
    popS      = 1'b0;
    selValidS = 1'b0;
    selAddrS  = 5'd0;
    selDataS  = 32'd0;
    if (forcedS) begin
      popS      = 1'b1;
      selValidS = 1'b1;
      selAddrS  = addrMemR[rdPtrR];
      selDataS  = dataMemR[rdPtrR];
    end else if (pipeEffS) begin
      selValidS = 1'b1;
      selAddrS  = wb.PipeAddr;
      selDataS  = wb.PipeData;
    end else if (fifoNonEmptyS) begin
      popS      = 1'b1;
      selValidS = 1'b1;
      selAddrS  = addrMemR[rdPtrR];
      selDataS  = dataMemR[rdPtrR];
    end else begin
      popS      = 1'b0;
      selValidS = 1'b0;
    end
  end

  // Register the write port; address/data hold when nothing is selected
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wb.EnW   <= 1'b0;
      wb.AddrW <= 5'd0;
      wb.DataW <= 32'd0;
    end else if (selValidS) begin
      wb.EnW   <= 1'b1;
      wb.AddrW <= selAddrS;
      wb.DataW <= selDataS;
    end else begin
      wb.EnW   <= 1'b0;
      wb.AddrW <= wb.AddrW;
      wb.DataW <= wb.DataW;
    end
  end

  // FIFO pointers and occupancy; reset flushes all queued results
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtrR <= PtrZero;
      rdPtrR <= PtrZero;
      countR <= CountZero;
    end else begin
      if (storeS) begin
        wrPtrR <= wrPtrR + PtrOne;
      end else begin
        wrPtrR <= wrPtrR;
      end
      if (popS) begin
        rdPtrR <= rdPtrR + PtrOne;
      end else begin
        rdPtrR <= rdPtrR;
      end
      case ({storeS, popS})
        2'b10:   countR <= countR + CountOne;
        2'b01:   countR <= countR - CountOne;
        default: countR <= countR;
      endcase
    end
  end

  // FIFO storage; entries need no reset because the count gates every read
  always_ff @(posedge Clock) begin
    if (storeS) begin
      addrMemR[wrPtrR] <= wb.MulAddr;
      dataMemR[wrPtrR] <= wb.MulData;
    end
  end
endmodule

// File: tb/tb_write_back_arbiter.sv
// Bench for write_back_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a queue-based
// model of the arbitration rules. Builds with or without WB_STARVE_GUARD_EN.
module tb_write_back_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic Clock;
  logic Reset;

  write_back_arbiter_if wbIf ();

  write_back_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .wb    (wbIf)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  int          total = 0;
  int          bad   = 0;
  bit          checkOn = 1'b0;

  // Reference model state
  entry_t      mq[$];
  logic        mEnW;
  logic [4:0]  mAddrW;
  logic [31:0] mDataW;
`ifdef WB_STARVE_GUARD_EN
  int          mStarve;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mForced();
`ifdef WB_STARVE_GUARD_EN
    return (mq.size() != 0) && (mStarve == STARVE_LIMIT);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle();
    wbIf.PipeEn   = 1'b0;
    wbIf.PipeAddr = 5'd0;
    wbIf.PipeData = 32'd0;
    wbIf.MulValid = 1'b0;
    wbIf.MulAddr  = 5'd0;
    wbIf.MulData  = 32'd0;
  endtask

  // Advance one cycle: model consumes this cycle's inputs after the mid-cycle
  // compare, then returns just after the next rising edge.
  task automatic tick();
    entry_t e;
    bit     eff;
    bit     nonEmpty;
    bit     ready;
    @(negedge Clock);
    #1;
    if (Reset) begin
      mq.delete();
`ifdef WB_STARVE_GUARD_EN
      mStarve = 0;
`endif
      mEnW   = 1'b0;
      mAddrW = 5'd0;
      mDataW = 32'd0;
    end else begin
      eff      = wbIf.PipeEn && (wbIf.PipeAddr != 5'd31);
      nonEmpty = (mq.size() != 0);
      ready    = (mq.size() < DEPTH);
`ifdef WB_STARVE_GUARD_EN
      if (nonEmpty && eff && !mForced()) mStarve = mStarve + 1;
      else mStarve = 0;
`endif
      mEnW = 1'b1;
      if (mForced() || (!eff && nonEmpty)) begin
        e      = mq.pop_front();
        mAddrW = e.addr;
        mDataW = e.data;
      end else if (eff) begin
        mAddrW = wbIf.PipeAddr;
        mDataW = wbIf.PipeData;
      end else begin
        mEnW = 1'b0;
      end
      if (wbIf.MulValid && ready && (wbIf.MulAddr != 5'd31)) begin
        e.addr = wbIf.MulAddr;
        e.data = wbIf.MulData;
        mq.push_back(e);
      end
    end
    @(posedge Clock);
    #1;
  endtask

  // Mid-cycle compare of every DUT output against the model
  always @(negedge Clock) begin
    if (checkOn) begin
      chk("cyc_EnW",        32'(wbIf.EnW),        32'(mEnW));
      chk("cyc_AddrW",      32'(wbIf.AddrW),      32'(mAddrW));
      chk("cyc_DataW",      wbIf.DataW,           mDataW);
      chk("cyc_MulReady",   32'(wbIf.MulReady),   32'(!Reset && (mq.size() < DEPTH)));
      chk("cyc_MulPending", 32'(wbIf.MulPending), 32'(mq.size() != 0));
      chk("cyc_PipeStall",  32'(wbIf.PipeStall),  32'(!Reset && mForced()));
    end
  end

  int         firstStall;
  int         stallCnt;
  logic       enAfterStall;
  logic [4:0] addrAfterStall;
  int         firstDrain;
  int         pipeProb;

  initial begin
    idle();
    Reset = 1'b1;
    tick();
    checkOn = 1'b1;

    // Reset values
    chk("rst_EnW",        32'(wbIf.EnW),        32'd0);
    chk("rst_AddrW",      32'(wbIf.AddrW),      32'd0);
    chk("rst_DataW",      wbIf.DataW,           32'd0);
    chk("rst_MulReady",   32'(wbIf.MulReady),   32'd0);
    chk("rst_PipeStall",  32'(wbIf.PipeStall),  32'd0);
    chk("rst_MulPending", 32'(wbIf.MulPending), 32'd0);
    tick();
    Reset = 1'b0;
    #1;
    chk("rel_MulReady", 32'(wbIf.MulReady), 32'd1);

    // Pipeline write lands one cycle later
    wbIf.PipeEn   = 1'b1;
    wbIf.PipeAddr = 5'd3;
    wbIf.PipeData = 32'h1234_5678;
    tick();
    chk("pipe_EnW",      32'(wbIf.EnW),      32'd1);
    chk("pipe_AddrW",    32'(wbIf.AddrW),    32'd3);
    chk("pipe_DataW",    wbIf.DataW,         32'h1234_5678);
    chk("pipe_MulReady", 32'(wbIf.MulReady), 32'd1);

    // Single multi-cycle result: pending in N+1, written in N+2
    idle();
    tick();
    wbIf.MulValid = 1'b1;
    wbIf.MulAddr  = 5'd5;
    wbIf.MulData  = 32'hA5A5_A5A5;
    tick();
    idle();
    chk("mul_n1_Pending", 32'(wbIf.MulPending), 32'd1);
    chk("mul_n1_EnW",     32'(wbIf.EnW),        32'd0);
    tick();
    chk("mul_n2_EnW",     32'(wbIf.EnW),        32'd1);
    chk("mul_n2_AddrW",   32'(wbIf.AddrW),      32'd5);
    chk("mul_n2_DataW",   wbIf.DataW,           32'hA5A5_A5A5);
    chk("mul_n2_Pending", 32'(wbIf.MulPending), 32'd0);
    tick();
    chk("mul_n3_EnW", 32'(wbIf.EnW), 32'd0);

    // Zero-register destinations on both sources
    wbIf.PipeEn   = 1'b1;
    wbIf.PipeAddr = 5'd31;
    wbIf.PipeData = 32'hDEAD_BEEF;
    wbIf.MulValid = 1'b1;
    wbIf.MulAddr  = 5'd31;
    wbIf.MulData  = 32'hCAFE_F00D;
    #1;
    chk("zr_MulReady", 32'(wbIf.MulReady), 32'd1);
    tick();
    idle();
    chk("zr_EnW",     32'(wbIf.EnW),        32'd0);
    chk("zr_Pending", 32'(wbIf.MulPending), 32'd0);
    tick();
    tick();

    // Fill the FIFO while the pipeline writes every cycle (cycles 0..3)
    for (int i = 0; i < 4; i++) begin
      wbIf.PipeEn   = 1'b1;
      wbIf.PipeAddr = 5'd1;
      wbIf.PipeData = $urandom();
      wbIf.MulValid = 1'b1;
      wbIf.MulAddr  = 5'(10 + i);
      wbIf.MulData  = 32'hD000_0000 + 32'(i);
      tick();
    end
    wbIf.MulValid = 1'b0;
    chk("full_MulReady", 32'(wbIf.MulReady), 32'd0);
    firstStall     = -1;
    stallCnt       = 0;
    enAfterStall   = 1'b0;
    addrAfterStall = 5'd0;
    for (int c = 4; c <= 12; c++) begin
      if (firstStall >= 0 && c == firstStall + 1) begin
        enAfterStall   = wbIf.EnW;
        addrAfterStall = wbIf.AddrW;
      end
      if (wbIf.PipeStall) begin
        stallCnt = stallCnt + 1;
        if (firstStall < 0) firstStall = c;
      end
      wbIf.PipeData = $urandom();
      tick();
    end
`ifdef WB_STARVE_GUARD_EN
    // Blocked cycles 1..8 bring the counter to the limit, so cycle 9 is forced
    chk("starve_first_cycle", 32'(firstStall), 32'd9);
    chk("starve_pulses",      32'(stallCnt),   32'd1);
    chk("starve_head_EnW",    32'(enAfterStall),   32'd1);
    chk("starve_head_AddrW",  32'(addrAfterStall), 32'd10);
    firstDrain = 11;
`else
    chk("nostarve_pulses", 32'(stallCnt), 32'd0);
    firstDrain = 10;
`endif
    // Release the pipeline: FIFO drains in push order from the next cycle
    idle();
    for (int a = firstDrain; a <= 13; a++) begin
      tick();
      chk("drain_EnW",   32'(wbIf.EnW),   32'd1);
      chk("drain_AddrW", 32'(wbIf.AddrW), 32'(a));
      chk("drain_DataW", wbIf.DataW,      32'hD000_0000 + 32'(a - 10));
    end
    chk("drain_Pending", 32'(wbIf.MulPending), 32'd0);
    tick();
    chk("drain_done_EnW", 32'(wbIf.EnW), 32'd0);

    // Reset with three queued entries and a pipeline write in flight
    for (int i = 0; i < 3; i++) begin
      wbIf.PipeEn   = 1'b1;
      wbIf.PipeAddr = 5'd2;
      wbIf.PipeData = $urandom();
      wbIf.MulValid = 1'b1;
      wbIf.MulAddr  = 5'(20 + i);
      wbIf.MulData  = $urandom();
      tick();
    end
    wbIf.MulValid = 1'b0;
    chk("prerst_Pending", 32'(wbIf.MulPending), 32'd1);
    Reset = 1'b1;
    tick();
    chk("midrst_EnW",      32'(wbIf.EnW),        32'd0);
    chk("midrst_Pending",  32'(wbIf.MulPending), 32'd0);
    chk("midrst_MulReady", 32'(wbIf.MulReady),   32'd0);
    Reset = 1'b0;
    idle();
    #1;
    chk("postrst_MulReady", 32'(wbIf.MulReady), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_no_stale_EnW", 32'(wbIf.EnW), 32'd0);
    end

    // Randomized traffic, alternating light and heavy pipeline load
    for (int k = 0; k < 600; k++) begin
      pipeProb      = ((k / 100) % 2 == 1) ? 95 : 40;
      Reset         = ($urandom_range(0, 199) == 0);
      wbIf.PipeEn   = ($urandom_range(0, 99) < pipeProb);
      wbIf.PipeAddr = 5'($urandom_range(0, 31));
      wbIf.PipeData = $urandom();
      wbIf.MulValid = ($urandom_range(0, 1) == 1);
      wbIf.MulAddr  = 5'($urandom_range(0, 31));
      wbIf.MulData  = $urandom();
      tick();
    end
    Reset = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
